// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with partial tags, 2-bit direction counters
// and a hardware sweep that invalidates every entry after reset or on request.
module branch_target_predictor #(
  parameter int PC_W       = 16,
  parameter int INDEX_BITS = 10,
  parameter int TAG_BITS   = 4,
  parameter int CTR_INIT   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] lookup_pc,
  output logic [PC_W-1:0] predicted_pc,
  output logic            predict_hit,
  output logic            predict_taken,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            clear_req,
  output logic            busy
);

  localparam int DEPTH = 1 << INDEX_BITS;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [INDEX_BITS-1:0]   r_ptr;
  logic [INDEX_BITS-1:0]   w_ptr_nxt;
  logic                    r_busy;
  logic                    w_busy_nxt;
  logic                    w_clr_en;
  logic                    w_upd_en;

  logic [DEPTH-1:0]        r_valid;
  logic [TAG_BITS-1:0]     r_tag    [DEPTH];
  logic [PC_W-1:0]         r_target [DEPTH];
  logic [1:0]              r_ctr    [DEPTH];

  logic [INDEX_BITS-1:0]   w_lk_idx;
  logic [TAG_BITS-1:0]     w_lk_tag;
  logic [INDEX_BITS-1:0]   w_up_idx;
  logic [TAG_BITS-1:0]     w_up_tag;
  logic                    w_up_hit;
  logic                    w_unused;

  assign w_lk_idx = lookup_pc[INDEX_BITS:1];
  assign w_lk_tag = lookup_pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
  assign w_up_idx = upd_pc[INDEX_BITS:1];
  assign w_up_tag = upd_pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign busy     = r_busy;
  // Bit 0 and the bits above the tag never take part in indexing or matching.
  assign w_unused = ^{lookup_pc, upd_pc};

  // Clear FSM state register; reset forces a fresh sweep from entry 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_ptr   <= {INDEX_BITS{1'b0}};
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Clear FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = {INDEX_BITS{1'b0}};
          w_busy_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (&r_ptr) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_ptr_nxt   = r_ptr + {{(INDEX_BITS-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_ptr_nxt   = {INDEX_BITS{1'b0}};
        w_busy_nxt  = 1'b1;
      end
    endcase
  end

  // Clear FSM outputs; a clear request in IDLE wins over a same-cycle update.
  always_comb begin
    w_clr_en = 1'b0;
    w_upd_en = 1'b0;
    case (r_state)
      ST_IDLE:  w_upd_en = upd_valid && !clear_req;
      ST_CLEAR: w_clr_en = 1'b1;
      default:  w_clr_en = 1'b0;
    endcase
  end

  // Table write port: sweep invalidation or resolved-jump training.
  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_valid[r_ptr] <= 1'b0;
    end else if (w_upd_en) begin
      if (w_up_hit) begin
        if (upd_taken) begin
          if (r_ctr[w_up_idx] != 2'b11) r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'b01;
          r_target[w_up_idx] <= upd_target;
        end else if (r_ctr[w_up_idx] != 2'b00) begin
          r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= upd_target;
        r_ctr[w_up_idx]    <= 2'(CTR_INIT);
      end
    end
  end

  // Combinational lookup; sees pre-update contents when indices collide.
  always_comb begin
    predict_hit   = !r_busy && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    predict_taken = predict_hit && r_ctr[w_lk_idx][1];
    if (predict_taken) begin
      predicted_pc = r_target[w_lk_idx];
    end else begin
      predicted_pc = lookup_pc + PC_W'(2);
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor (8 entries, 4-bit tags) with a
// per-cycle comparison against a table-level behavioural model.
module tb_branch_target_predictor;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] lookup_pc = 16'h0010;
  logic [15:0] predicted_pc;
  logic        predict_hit;
  logic        predict_taken;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = 16'h0000;
  logic        upd_taken = 1'b0;
  logic [15:0] upd_target = 16'h0000;
  logic        clear_req = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  branch_target_predictor #(
    .PC_W(16), .INDEX_BITS(3), .TAG_BITS(4), .CTR_INIT(2)
  ) dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .predicted_pc(predicted_pc),
    .predict_hit(predict_hit), .predict_taken(predict_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .clear_req(clear_req), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: table of entries plus the number of sweep edges still to come.
  int          m_busy_left = DEPTH;
  bit          m_valid  [DEPTH];
  int          m_tag    [DEPTH];
  int          m_ctr    [DEPTH];
  logic [15:0] m_target [DEPTH];
  int          u_idx, u_tag;
  assign u_idx = int'(upd_pc) / 2 % DEPTH;
  assign u_tag = int'(upd_pc) / 16 % 16;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy_left <= DEPTH;
      for (int i = 0; i < DEPTH; i++) m_valid[i] <= 1'b0;
    end else if (m_busy_left != 0) begin
      m_busy_left <= m_busy_left - 1;
    end else if (clear_req) begin
      m_busy_left <= DEPTH;
      for (int i = 0; i < DEPTH; i++) m_valid[i] <= 1'b0;
    end else if (upd_valid) begin
      if (m_valid[u_idx] && m_tag[u_idx] == u_tag) begin
        if (upd_taken) begin
          m_ctr[u_idx]    <= (m_ctr[u_idx] >= 3) ? 3 : m_ctr[u_idx] + 1;
          m_target[u_idx] <= upd_target;
        end else begin
          m_ctr[u_idx]    <= (m_ctr[u_idx] <= 0) ? 0 : m_ctr[u_idx] - 1;
        end
      end else if (upd_taken) begin
        m_valid[u_idx]  <= 1'b1;
        m_tag[u_idx]    <= u_tag;
        m_target[u_idx] <= upd_target;
        m_ctr[u_idx]    <= 2;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the rising edge.
  always @(negedge clk) begin : cmp
    int          l_idx, l_tag;
    logic        e_busy, e_hit, e_tk;
    logic [15:0] e_pc;
    l_idx  = int'(lookup_pc) / 2 % DEPTH;
    l_tag  = int'(lookup_pc) / 16 % 16;
    e_busy = (m_busy_left != 0);
    e_hit  = !e_busy && m_valid[l_idx] && (m_tag[l_idx] == l_tag);
    e_tk   = e_hit && (m_ctr[l_idx] >= 2);
    e_pc   = e_tk ? m_target[l_idx] : 16'((int'(lookup_pc) + 2) % 65536);
    chk("model_busy", 32'(busy), 32'(e_busy));
    chk("model_hit", 32'(predict_hit), 32'(e_hit));
    chk("model_taken", 32'(predict_taken), 32'(e_tk));
    chk("model_pc", 32'(predicted_pc), 32'(e_pc));
  end

  task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tgt;
    @(posedge clk);
    #2;
    upd_valid  = 1'b0;
  endtask

  task automatic look(input string name, input logic [15:0] pc, input logic e_hit,
                      input logic e_tk, input logic [15:0] e_pc);
    @(posedge clk);
    #2;
    lookup_pc = pc;
    #1;
    chk({name, "_hit"}, 32'(predict_hit), 32'(e_hit));
    chk({name, "_taken"}, 32'(predict_taken), 32'(e_tk));
    chk({name, "_pc"}, 32'(predicted_pc), 32'(e_pc));
  endtask

  // Counts rising edges until busy is seen low just after one; bounded.
  task automatic count_busy(input int first, output int n);
    n = first;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      n++;
      #1;
      if (!busy) break;
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_hit", 32'(predict_hit), 32'h0);
    chk("rst_taken", 32'(predict_taken), 32'h0);
    chk("rst_pc", 32'(predicted_pc), 32'h0012);

    // 1: sweep after reset release
    reset = 1'b0;
    count_busy(0, n);
    chk("reset_sweep_len", 32'(n), 32'd8);
    look("miss10", 16'h0010, 1'b0, 1'b0, 16'h0012);
    look("wrap", 16'hFFFE, 1'b0, 1'b0, 16'h0000);

    // 2: allocate, no same-cycle bypass
    @(posedge clk);
    #2;
    lookup_pc  = 16'h0004;
    upd_valid  = 1'b1;
    upd_pc     = 16'h0004;
    upd_taken  = 1'b1;
    upd_target = 16'h0040;
    #1;
    chk("same_cycle_hit", 32'(predict_hit), 32'h0);
    chk("same_cycle_pc", 32'(predicted_pc), 32'h0006);
    @(posedge clk);
    #2;
    upd_valid = 1'b0;
    #1;
    chk("alloc_hit", 32'(predict_hit), 32'h1);
    chk("alloc_taken", 32'(predict_taken), 32'h1);
    chk("alloc_pc", 32'(predicted_pc), 32'h0040);

    // 3: counter behaviour
    upd(16'h0004, 1'b0, 16'h0000);
    look("ctr1", 16'h0004, 1'b1, 1'b0, 16'h0006);
    for (int i = 0; i < 4; i++) upd(16'h0004, 1'b1, 16'h0040);
    upd(16'h0004, 1'b0, 16'h0000);
    look("ctr_sat", 16'h0004, 1'b1, 1'b1, 16'h0040);

    // 4: aliasing and not-taken miss
    look("alias_miss", 16'h0014, 1'b0, 1'b0, 16'h0016);
    upd(16'h0014, 1'b1, 16'h0100);
    look("alias_new", 16'h0014, 1'b1, 1'b1, 16'h0100);
    look("alias_old", 16'h0004, 1'b0, 1'b0, 16'h0006);
    upd(16'h0008, 1'b0, 16'h0200);
    look("nt_miss", 16'h0008, 1'b0, 1'b0, 16'h000A);
    upd(16'h000A, 1'b1, 16'h0300);
    look("idx5", 16'h000A, 1'b1, 1'b1, 16'h0300);

    // 5: clear request beats a simultaneous update; updates ignored while sweeping
    @(posedge clk);
    #2;
    clear_req  = 1'b1;
    upd_valid  = 1'b1;
    upd_pc     = 16'h000C;
    upd_taken  = 1'b1;
    upd_target = 16'h0500;
    @(posedge clk);
    #2;
    clear_req = 1'b0;
    chk("clear_busy", 32'(busy), 32'h1);
    count_busy(1, n);
    upd_valid = 1'b0;
    chk("clear_sweep_edges", 32'(n), 32'd9);
    for (int i = 0; i < DEPTH; i++)
      look("post_clear", 16'(2 * i), 1'b0, 1'b0, 16'(2 * i + 2));
    look("post_clear14", 16'h0014, 1'b0, 1'b0, 16'h0016);

    // 6: reset in the middle of a sweep restarts it
    upd(16'h0004, 1'b1, 16'h0040);
    look("refill", 16'h0004, 1'b1, 1'b1, 16'h0040);
    clear_req = 1'b1;
    @(posedge clk);
    #2;
    clear_req = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h1);
    chk("mid_rst_hit", 32'(predict_hit), 32'h0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    count_busy(0, n);
    chk("mid_rst_sweep_len", 32'(n), 32'd8);
    look("after_rst", 16'h0004, 1'b0, 1'b0, 16'h0006);
    upd(16'h0004, 1'b1, 16'h0044);
    look("after_rst_alloc", 16'h0004, 1'b1, 1'b1, 16'h0044);

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
